// File: rtl/reseed_sequencer_pkg.sv
// Shared definitions for the placement-seed reseed sequencer.
package reseed_sequencer_pkg;

   localparam int DEF_SET_IDX_BITS = 6;
   localparam int DEF_EPOCH_BITS   = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      FLUSH   = 3'd2,
      WB_WAIT = 3'd3,
      RESEED  = 3'd4
   } reseed_state_t;

endpackage

// File: rtl/reseed_epoch_counter.sv
// Saturating access counter for one placement epoch, with limit compare.
// An increment coinciding with a clear is kept, so the first access of the
// new epoch is never lost.
module reseed_epoch_counter
   import reseed_sequencer_pkg::*;
#(
   parameter int EPOCH_BITS = DEF_EPOCH_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_inc,
   input  logic                  i_clear,
   input  logic [EPOCH_BITS-1:0] i_limit,
   output logic                  o_epoch_hit
);

   logic [EPOCH_BITS-1:0] r_count;
   logic                  w_saturated;

   assign w_saturated = &r_count;

   // Count accepted accesses; clear at reseed, hold at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= i_inc ? EPOCH_BITS'(1) : '0;
      end else if (i_inc && !w_saturated) begin
         r_count <= r_count + 1'b1;
      end
   end

   // A zero limit disables automatic reseeding.
   assign o_epoch_hit = (i_limit != '0) && (r_count >= i_limit);

endmodule

// File: rtl/reseed_sequencer.sv
// Decides when the placement seed must change, quiesces the cache, sweeps
// every set through the writeback/invalidate port and then issues a single
// reseed pulse. All outputs decode from registers only.
//
// Flush handshake: a flush request transfers on a cycle where flush_valid
// and flush_ready are both high; while flush_valid is high and flush_ready
// is low, flush_set is held unchanged.
module reseed_sequencer
   import reseed_sequencer_pkg::*;
#(
   parameter int SET_IDX_BITS = DEF_SET_IDX_BITS,
   parameter int EPOCH_BITS   = DEF_EPOCH_BITS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [EPOCH_BITS-1:0]   epoch_limit,
   input  logic                    access_valid,
   input  logic                    sw_reseed_req,
   output logic                    quiesce_req,
   input  logic                    pipeline_idle,
   output logic                    flush_valid,
   output logic [SET_IDX_BITS-1:0] flush_set,
   input  logic                    flush_ready,
   input  logic                    wb_idle,
   output logic                    reseed,
   output logic                    busy
);

   localparam logic [SET_IDX_BITS-1:0] LAST_SET = {SET_IDX_BITS{1'b1}};

   reseed_state_t           r_state;
   reseed_state_t           w_next_state;
   logic [SET_IDX_BITS-1:0] r_set_ptr;
   logic [SET_IDX_BITS-1:0] w_set_ptr_next;
   logic                    r_pending;
   logic                    w_pending_next;
   logic                    w_epoch_hit;
   logic                    w_trigger;
   logic                    w_clear;

   assign w_clear   = (r_state == RESEED);
   assign w_trigger = r_pending || w_epoch_hit;

   reseed_epoch_counter #(
      .EPOCH_BITS (EPOCH_BITS)
   ) u_epoch_counter (
      .clk         (clk),
      .reset       (reset),
      .i_inc       (access_valid),
      .i_clear     (w_clear),
      .i_limit     (epoch_limit),
      .o_epoch_hit (w_epoch_hit)
   );

   // State, sweep pointer and pending software request registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_set_ptr <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_set_ptr <= w_set_ptr_next;
         r_pending <= w_pending_next;
      end
   end

   // Sequence control. A software request arriving while a sequence is
   // starting or running is absorbed into it; one arriving during the
   // reseed cycle itself is remembered and starts a fresh sequence.
   always_comb begin
      w_next_state   = r_state;
      w_set_ptr_next = r_set_ptr;
      w_pending_next = r_pending;
      case (r_state)
         IDLE: begin
            if (w_trigger) begin
               w_next_state   = DRAIN;
               w_pending_next = 1'b0;
            end else if (sw_reseed_req) begin
               w_pending_next = 1'b1;
            end
         end
         DRAIN: begin
            if (pipeline_idle) w_next_state = FLUSH;
         end
         FLUSH: begin
            if (flush_ready) begin
               w_set_ptr_next = r_set_ptr + 1'b1;
               if (r_set_ptr == LAST_SET) w_next_state = WB_WAIT;
            end
         end
         WB_WAIT: begin
            if (wb_idle) w_next_state = RESEED;
         end
         RESEED: begin
            w_next_state   = IDLE;
            w_set_ptr_next = '0;
            if (sw_reseed_req) w_pending_next = 1'b1;
         end
         default: begin
            w_next_state   = IDLE;
            w_set_ptr_next = '0;
         end
      endcase
   end

   assign quiesce_req = (r_state != IDLE);
   assign busy        = (r_state != IDLE);
   assign flush_valid = (r_state == FLUSH);
   assign reseed      = (r_state == RESEED);
   assign flush_set   = r_set_ptr;

endmodule
